// File: rtl/rv32v_decode_execute_pipe_pkg.sv
// Shared types for the rv32v decode->execute staging buffer.
// Execute unpacks the control word using the field enums below.
package rv32v_decode_execute_pipe_pkg;

  localparam int VLANES    = 2;
  localparam int DX_DATA_W = 32;
  localparam int DX_CTRL_W = 128;
  localparam int DX_IDX_W  = 4;

  typedef enum logic [2:0] {
    FU_ALU = 3'd0,
    FU_MUL = 3'd1,
    FU_DIV = 3'd2,
    FU_LSU = 3'd3,
    FU_PRM = 3'd4
  } fu_type_e;

  typedef enum logic [1:0] {
    SEW_8  = 2'd0,
    SEW_16 = 2'd1,
    SEW_32 = 2'd2
  } vsew_e;

  // One decode->execute transfer at the default lane count.
  typedef struct packed {
    logic [DX_CTRL_W-1:0]              ctrl;
    logic [DX_IDX_W-1:0]               index;
    logic [VLANES-1:0][DX_DATA_W-1:0]  vs1;
    logic [VLANES-1:0][DX_DATA_W-1:0]  vs2;
    logic [VLANES-1:0][DX_DATA_W-1:0]  vs3;
    logic [VLANES-1:0]                 mask;
  } dx_entry_t;

endpackage

// File: rtl/rv32v_decode_execute_pipe_if.sv
// Decode->execute handshake bundle; master is the decode/execute environment,
// slave is the staging buffer.
interface rv32v_decode_execute_pipe_if #(
  parameter int NUM_LANES = 2,
  parameter int DATA_W    = 32,
  parameter int CTRL_W    = 128,
  parameter int DEPTH     = 2,
  parameter int IDX_W     = 4
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic                          in_valid;
  logic                          in_ready;
  logic [CTRL_W-1:0]             in_ctrl;
  logic [IDX_W-1:0]              in_index;
  logic [NUM_LANES*DATA_W-1:0]   in_vs1;
  logic [NUM_LANES*DATA_W-1:0]   in_vs2;
  logic [NUM_LANES*DATA_W-1:0]   in_vs3;
  logic [NUM_LANES-1:0]          in_mask;

  logic                          out_valid;
  logic                          out_ready;
  logic [CTRL_W-1:0]             out_ctrl;
  logic [IDX_W-1:0]              out_index;
  logic [NUM_LANES*DATA_W-1:0]   out_vs1;
  logic [NUM_LANES*DATA_W-1:0]   out_vs2;
  logic [NUM_LANES*DATA_W-1:0]   out_vs3;
  logic [NUM_LANES-1:0]          out_mask;

  logic                          flush;
  logic                          kill_valid;
  logic [IDX_W-1:0]              kill_index;
  logic [OCC_W-1:0]              occupancy;

  modport master (
    output in_valid, in_ctrl, in_index, in_vs1, in_vs2, in_vs3, in_mask,
    output out_ready, flush, kill_valid, kill_index,
    input  in_ready, out_valid, out_ctrl, out_index, out_vs1, out_vs2, out_vs3, out_mask,
    input  occupancy
  );

  modport slave (
    input  in_valid, in_ctrl, in_index, in_vs1, in_vs2, in_vs3, in_mask,
    input  out_ready, flush, kill_valid, kill_index,
    output in_ready, out_valid, out_ctrl, out_index, out_vs1, out_vs2, out_vs3, out_mask,
    output occupancy
  );
endinterface

// File: rtl/rv32v_decode_execute_pipe.sv
// DEPTH-entry valid/ready staging FIFO between rv32v decode and execute,
// with full flush and squash-by-completion-index.
module rv32v_decode_execute_pipe
  import rv32v_decode_execute_pipe_pkg::*;
#(
  parameter int NUM_LANES = VLANES,
  parameter int DATA_W    = DX_DATA_W,
  parameter int CTRL_W    = DX_CTRL_W,
  parameter int DEPTH     = 2,
  parameter int IDX_W     = DX_IDX_W
) (
  input logic                   i_clk,
  input logic                   i_rst,
  rv32v_decode_execute_pipe_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef struct packed {
    logic [CTRL_W-1:0]                 ctrl;
    logic [IDX_W-1:0]                  index;
    logic [NUM_LANES-1:0][DATA_W-1:0]  vs1;
    logic [NUM_LANES-1:0][DATA_W-1:0]  vs2;
    logic [NUM_LANES-1:0][DATA_W-1:0]  vs3;
    logic [NUM_LANES-1:0]              mask;
  } entry_t;

  entry_t            r_mem [DEPTH];
  logic [DEPTH-1:0]  r_live;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [OCC_W-1:0]  r_count;

  entry_t            w_head;
  entry_t            w_in_entry;
  logic              w_nonempty;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_head_kill;
  logic              w_in_live;
  logic              w_push;
  logic              w_pop;
  logic [DEPTH-1:0]  w_live_nxt;

  function automatic logic [OCC_W-1:0] popcnt(input logic [DEPTH-1:0] v);
    logic [OCC_W-1:0] n;
    n = '0;
    for (int i = 0; i < DEPTH; i++) n = n + OCC_W'(v[i]);
    return n;
  endfunction

  assign w_head      = r_mem[r_rd_ptr];
  assign w_nonempty  = (r_count != '0);
  assign w_in_ready  = (r_count < OCC_W'(DEPTH));
  assign w_out_valid = r_live[r_rd_ptr] & w_nonempty;
  assign w_head_kill = bus.kill_valid & (w_head.index == bus.kill_index);
  assign w_in_live   = ~(bus.kill_valid & (bus.in_index == bus.kill_index));
  assign w_push      = bus.in_valid & w_in_ready;
  // Dead heads drain on their own; a live head killed this cycle is left for that path.
  assign w_pop       = w_nonempty & (~r_live[r_rd_ptr] | (bus.out_ready & ~w_head_kill));

  assign w_in_entry.ctrl  = bus.in_ctrl;
  assign w_in_entry.index = bus.in_index;
  assign w_in_entry.vs1   = bus.in_vs1;
  assign w_in_entry.vs2   = bus.in_vs2;
  assign w_in_entry.vs3   = bus.in_vs3;
  assign w_in_entry.mask  = bus.in_mask;

  always_comb begin
    w_live_nxt = r_live;
    for (int i = 0; i < DEPTH; i++)
      if (bus.kill_valid && (r_mem[i].index == bus.kill_index)) w_live_nxt[i] = 1'b0;
    if (w_pop)  w_live_nxt[r_rd_ptr] = 1'b0;
    if (w_push) w_live_nxt[r_wr_ptr] = w_in_live;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_live   <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_live   <= '0;
    end else begin
      r_live <= w_live_nxt;
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_in_entry;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + OCC_W'(w_push) - OCC_W'(w_pop);
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_ctrl  = w_head.ctrl;
  assign bus.out_index = w_head.index;
  assign bus.out_vs1   = w_head.vs1;
  assign bus.out_vs2   = w_head.vs2;
  assign bus.out_vs3   = w_head.vs3;
  assign bus.out_mask  = w_head.mask;
  assign bus.occupancy = popcnt(r_live);

endmodule

// File: tb/tb_rv32v_decode_execute_pipe.sv
// Scoreboard bench for the decode->execute staging buffer (4 lanes, 2 entries).
module tb_rv32v_decode_execute_pipe;

  localparam int NL  = 4;
  localparam int DW  = 32;
  localparam int CW  = 128;
  localparam int DEP = 2;
  localparam int IW  = 4;

  typedef struct {
    logic [CW-1:0]    ctrl;
    logic [IW-1:0]    idx;
    logic [NL*DW-1:0] vs1;
    logic [NL*DW-1:0] vs2;
    logic [NL*DW-1:0] vs3;
    logic [NL-1:0]    mask;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  int   n_pop = 0;
  ent_t sbq [$];

  always #5 clk = ~clk;

  rv32v_decode_execute_pipe_if #(.NUM_LANES(NL), .DATA_W(DW), .CTRL_W(CW), .DEPTH(DEP), .IDX_W(IW)) bus ();

  rv32v_decode_execute_pipe #(.NUM_LANES(NL), .DATA_W(DW), .CTRL_W(CW), .DEPTH(DEP), .IDX_W(IW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [IW-1:0] idx);
    bus.in_valid = 1'b1;
    bus.in_index = idx;
    bus.in_ctrl  = {$urandom, $urandom, $urandom, $urandom};
    bus.in_vs1   = {$urandom, $urandom, $urandom, $urandom};
    bus.in_vs2   = {$urandom, $urandom, $urandom, $urandom};
    bus.in_vs3   = {$urandom, $urandom, $urandom, $urandom};
    bus.in_mask  = NL'($urandom);
  endtask

  // Sample just before the rising edge, update the model, then return at the falling edge.
  task automatic cyc();
    ent_t e;
    #4;
    if (rst || bus.flush) begin
      sbq.delete();
    end else begin
      if (bus.out_valid && bus.out_ready && !(bus.kill_valid && bus.out_index == bus.kill_index)) begin
        if (sbq.size() == 0) begin
          chk("sb_underflow", 128'(sbq.size()), 128'd1);
        end else begin
          e = sbq.pop_front();
          n_pop++;
          chk("sb_index", 128'(bus.out_index), 128'(e.idx));
          chk("sb_ctrl",  bus.out_ctrl, e.ctrl);
          chk("sb_vs1",   bus.out_vs1,  e.vs1);
          chk("sb_vs2",   bus.out_vs2,  e.vs2);
          chk("sb_vs3",   bus.out_vs3,  e.vs3);
          chk("sb_mask",  128'(bus.out_mask), 128'(e.mask));
        end
      end
      if (bus.kill_valid)
        for (int i = sbq.size() - 1; i >= 0; i--)
          if (sbq[i].idx == bus.kill_index) sbq.delete(i);
      if (bus.in_valid && bus.in_ready && !(bus.kill_valid && bus.in_index == bus.kill_index)) begin
        e.ctrl = bus.in_ctrl; e.idx = bus.in_index; e.vs1 = bus.in_vs1;
        e.vs2  = bus.in_vs2;  e.vs3 = bus.in_vs3;   e.mask = bus.in_mask;
        sbq.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [CW-1:0] a_ctrl;
    int            pop0;

    bus.in_valid = 0; bus.in_ctrl = '0; bus.in_index = '0; bus.in_vs1 = '0;
    bus.in_vs2 = '0;  bus.in_vs3 = '0;  bus.in_mask = '0;  bus.out_ready = 0;
    bus.flush = 0;    bus.kill_valid = 0; bus.kill_index = '0;
    cyc(); cyc();
    rst = 0;
    cyc();
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_in_ready",  128'(bus.in_ready),  128'd1);
    chk("rst_occ",       128'(bus.occupancy), 128'd0);
    chk("rst_payload",   bus.out_vs2, 128'd0);

    // single push, held by stalled consumer
    drive(4'd3); a_ctrl = bus.in_ctrl;
    cyc();
    bus.in_valid = 0;
    chk("t1_out_valid", 128'(bus.out_valid), 128'd1);
    chk("t1_out_index", 128'(bus.out_index), 128'd3);
    chk("t1_occ",       128'(bus.occupancy), 128'd1);
    chk("t1_in_ready",  128'(bus.in_ready),  128'd1);

    drive(4'd4);
    cyc();
    bus.in_valid = 0;
    chk("t2_in_ready", 128'(bus.in_ready),  128'd0);
    chk("t2_occ",      128'(bus.occupancy), 128'd2);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t2_hold_idx",  128'(bus.out_index), 128'd3);
      chk("t2_hold_ctrl", bus.out_ctrl, a_ctrl);
    end
    bus.out_ready = 1;
    cyc();
    chk("t2_b_next", 128'(bus.out_index), 128'd4);
    chk("t2_b_valid", 128'(bus.out_valid), 128'd1);
    cyc();
    chk("t2_drained", 128'(bus.occupancy), 128'd0);

    // streaming
    pop0 = n_pop;
    for (int i = 0; i < 8; i++) begin
      drive(IW'(i + 8));
      cyc();
      chk("t3_occ", 128'(bus.occupancy), 128'd1);
    end
    bus.in_valid = 0;
    cyc();
    chk("t3_pops", 128'(n_pop - pop0), 128'd8);
    chk("t3_empty", 128'(bus.occupancy), 128'd0);

    // kill the head
    bus.out_ready = 0;
    drive(4'd5); cyc();
    drive(4'd6); cyc();
    bus.in_valid = 0; bus.kill_valid = 1; bus.kill_index = 4'd5;
    cyc();
    bus.kill_valid = 0;
    chk("t4_dead_valid", 128'(bus.out_valid), 128'd0);
    chk("t4_dead_occ",   128'(bus.occupancy), 128'd1);
    cyc();
    chk("t4_next_valid", 128'(bus.out_valid), 128'd1);
    chk("t4_next_idx",   128'(bus.out_index), 128'd6);
    chk("t4_next_occ",   128'(bus.occupancy), 128'd1);
    bus.out_ready = 1;
    cyc();
    chk("t4_drained", 128'(bus.occupancy), 128'd0);

    // incoming entry killed on arrival
    drive(4'd10); bus.kill_valid = 1; bus.kill_index = 4'd10;
    cyc();
    bus.in_valid = 0; bus.kill_valid = 0;
    chk("tk_valid", 128'(bus.out_valid), 128'd0);
    chk("tk_occ",   128'(bus.occupancy), 128'd0);
    cyc();
    chk("tk_in_ready", 128'(bus.in_ready), 128'd1);

    // flush, full and partially full
    bus.out_ready = 0;
    drive(4'd7); cyc();
    drive(4'd8); cyc();
    drive(4'd9); bus.flush = 1;
    cyc();
    bus.flush = 0; bus.in_valid = 0;
    chk("t5_valid",    128'(bus.out_valid), 128'd0);
    chk("t5_occ",      128'(bus.occupancy), 128'd0);
    chk("t5_in_ready", 128'(bus.in_ready),  128'd1);
    drive(4'd11); cyc();
    drive(4'd12); bus.flush = 1;
    cyc();
    bus.flush = 0; bus.in_valid = 0;
    chk("t5b_valid", 128'(bus.out_valid), 128'd0);
    chk("t5b_occ",   128'(bus.occupancy), 128'd0);
    bus.out_ready = 1;
    cyc(); cyc();
    chk("t5_never_seen", 128'(bus.out_valid), 128'd0);

    // lane placement, then reset mid-stream
    bus.out_ready = 0;
    drive(4'd2); bus.in_vs2[95:64] = 32'hDEADBEEF; bus.in_mask = 4'b0101;
    cyc();
    bus.in_valid = 0;
    chk("t6_lane2_vs2", 128'(bus.out_vs2[95:64]), 128'hDEADBEEF);
    chk("t6_mask",      128'(bus.out_mask), 128'h5);
    drive(4'd13); rst = 1;
    cyc();
    rst = 0; bus.in_valid = 0;
    chk("t6_rst_occ",      128'(bus.occupancy), 128'd0);
    chk("t6_rst_valid",    128'(bus.out_valid), 128'd0);
    chk("t6_rst_in_ready", 128'(bus.in_ready),  128'd1);
    chk("t6_rst_payload",  128'(bus.out_index), 128'd0);

    bus.out_ready = 1;
    cyc(); cyc(); cyc();
    chk("sb_leftover", 128'(sbq.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
